// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control, resolves
// EX/MEM and MEM/WB forwarding onto the ALU operand buses, and inserts bubbles on load-use or flush.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [31:0]      id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [3:0]       id_alu_control,
    input  logic             id_alu_src,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             flush,
    input  logic             exmem_reg_write,
    input  logic [4:0]       exmem_dest,
    input  logic [31:0]      exmem_result,
    input  logic             memwb_reg_write,
    input  logic [4:0]       memwb_dest,
    input  logic [31:0]      memwb_result,
    output logic [31:0]      data1,
    output logic [31:0]      data2,
    output logic [3:0]       alu_control,
    output logic [4:0]       shift_amount,
    output logic             ex_valid,
    output logic [4:0]       ex_dest,
    output logic [31:0]      ex_store_data,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             stall_out,
    output logic [CNT_W-1:0] bubble_count
);

    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] imm_q;
    logic        alu_src_q;
    logic        bubble;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    always_comb begin
        stall_out = ex_valid && ex_mem_read && (ex_dest != 5'd0) && id_valid &&
                    ((ex_dest == id_rs) || (ex_dest == id_rt));
        bubble    = flush || stall_out;
    end

    // EX/MEM is the younger result, so it is checked first; r0 is hardwired and never forwarded.
    always_comb begin
        fwd_rs = rs_data_q;
        if (exmem_reg_write && (exmem_dest == rs_q) && (rs_q != 5'd0))
            fwd_rs = exmem_result;
        else if (memwb_reg_write && (memwb_dest == rs_q) && (rs_q != 5'd0))
            fwd_rs = memwb_result;

        fwd_rt = rt_data_q;
        if (exmem_reg_write && (exmem_dest == rt_q) && (rt_q != 5'd0))
            fwd_rt = exmem_result;
        else if (memwb_reg_write && (memwb_dest == rt_q) && (rt_q != 5'd0))
            fwd_rt = memwb_result;
    end

    always_comb begin
        data1         = fwd_rs;
        ex_store_data = fwd_rt;
        data2         = alu_src_q ? imm_q : fwd_rt;
    end

    // Operand fields load on every non-reset edge; only valid, control and dest are bubbled.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_q          <= '0;
            rt_q          <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            alu_src_q     <= 1'b0;
            shift_amount  <= '0;
            alu_control   <= '0;
            ex_valid      <= 1'b0;
            ex_dest       <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
        end else begin
            rs_q         <= id_rs;
            rt_q         <= id_rt;
            rs_data_q    <= id_rs_data;
            rt_data_q    <= id_rt_data;
            imm_q        <= id_imm;
            alu_src_q    <= id_alu_src;
            shift_amount <= id_shamt;
            if (bubble) begin
                alu_control   <= '0;
                ex_valid      <= 1'b0;
                ex_dest       <= '0;
                ex_reg_write  <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_mem_to_reg <= 1'b0;
            end else begin
                alu_control   <= id_alu_control;
                ex_valid      <= id_valid;
                ex_dest       <= id_reg_dst ? id_rd : id_rt;
                ex_reg_write  <= id_valid && id_reg_write;
                ex_mem_read   <= id_valid && id_mem_read;
                ex_mem_write  <= id_valid && id_mem_write;
                ex_mem_to_reg <= id_valid && id_mem_to_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            bubble_count <= '0;
        else if (bubble && (bubble_count != '1))
            bubble_count <= bubble_count + 1'b1;
    end

endmodule
